ro_rng_ctrl: RTL and testbench

//  Controller/sequencer for the ring-oscillator RNG core (ro_top: en in, d_out[7:0] out).

---
 rtl/ro_rng_pkg.sv | 25 ++
 rtl/ro_rng_health.sv | 58 +++++
 rtl/ro_rng_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ro_rng_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_rng_pkg.sv
// ---------------------------------------------------------------------------
// ro_rng_pkg
// Shared types and sizing helpers for the ring-oscillator RNG controller.
//   state_e  : controller FSM states
//   SAMPLE_W : width of one RO sample
//   cnt_w()  : bits needed for a counter that runs 0..n-1
// ---------------------------------------------------------------------------
package ro_rng_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_COLLECT,
      ST_HOLD,
      ST_FAULT
   } state_e;

   localparam int unsigned SAMPLE_W = 8;

   // Minimum of one bit so degenerate parameter values still elaborate.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ro_rng_health.sv
// ---------------------------------------------------------------------------
// ro_rng_health
// Repetition-count health test on the captured RO samples.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : restart the test (run length back to 0)
//   cap_vld_i     : sample_i is a new capture this cycle
//   sample_i      : captured sample
//   fail_o        : REP_LIMIT identical consecutive captures have been seen
// The run length and previous sample survive word boundaries; only clr_i
// restarts them. The counter saturates at REP_LIMIT so fail_o holds.
// ---------------------------------------------------------------------------
module ro_rng_health
   import ro_rng_pkg::*;
#(
   parameter int unsigned REP_LIMIT = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                cap_vld_i,
   input  logic [SAMPLE_W-1:0] sample_i,
   output logic                fail_o
);

   localparam int unsigned REP_W = cnt_w(REP_LIMIT + 1);

   logic [REP_W-1:0]    rep_q, rep_d;
   logic [SAMPLE_W-1:0] prev_q, prev_d;

   always_comb begin
      rep_d  = rep_q;
      prev_d = prev_q;
      if (clr_i) begin
         rep_d = '0;
      end else if (cap_vld_i) begin
         prev_d = sample_i;
         // A zero run length means this is the first capture since clearing.
         if (rep_q == '0 || sample_i != prev_q) begin
            rep_d = REP_W'(1);
         end else if (rep_q != REP_W'(REP_LIMIT)) begin
            rep_d = rep_q + REP_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rep_q  <= '0;
         prev_q <= '0;
      end else begin
         rep_q  <= rep_d;
         prev_q <= prev_d;
      end
   end

   assign fail_o = (rep_q == REP_W'(REP_LIMIT));

endmodule

// File: rtl/ro_rng_ctrl.sv
// ---------------------------------------------------------------------------
// ro_rng_ctrl
// Sequencer for the ring-oscillator RNG core: enables the oscillators, waits
// a warm-up period, captures synchronised RO samples every SAMPLE_DIV cycles,
// packs OUT_W/8 of them into a word and hands it out over valid/ready. A
// repetition-count health test shuts the oscillators down and latches fault.
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : begin generation (IDLE only)
//   stop_i        : abort to IDLE from any non-FAULT state
//   ro_en_o       : oscillator enable
//   ro_data_i     : raw RO output, asynchronous to clk_i
//   out_data_o    : packed random word (byte k = capture k)
//   out_valid_o   : out_data_o valid
//   out_ready_i   : consumer accepts when out_valid_o & out_ready_i
//   busy_o        : not IDLE and not FAULT
//   fault_o       : sticky health-test failure
//   fault_clr_i   : leave FAULT to IDLE
// ---------------------------------------------------------------------------
module ro_rng_ctrl
   import ro_rng_pkg::*;
#(
   parameter int unsigned WARMUP_CYC = 16,
   parameter int unsigned SAMPLE_DIV = 4,
   parameter int unsigned OUT_W      = 32,
   parameter int unsigned REP_LIMIT  = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                stop_i,
   output logic                ro_en_o,
   input  logic [SAMPLE_W-1:0] ro_data_i,
   output logic [OUT_W-1:0]    out_data_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o,
   output logic                fault_o,
   input  logic                fault_clr_i
);

   localparam int unsigned N      = OUT_W / SAMPLE_W;
   localparam int unsigned WARM_W = cnt_w(WARMUP_CYC);
   localparam int unsigned DIV_W  = cnt_w(SAMPLE_DIV);
   localparam int unsigned IDX_W  = cnt_w(N);

   state_e              state_q, state_d;
   logic [WARM_W-1:0]   warm_q, warm_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [OUT_W-1:0]    data_q, data_d;
   logic                valid_q, valid_d;
   logic [SAMPLE_W-1:0] sync1_q, sync2_q;
   logic                cap_vld;
   logic                hlth_clr;
   logic                fail;

   // Two-flop synchroniser; captures always read the second stage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ro_data_i;
         sync2_q <= sync1_q;
      end
   end

   assign hlth_clr = (state_q == ST_IDLE) || (state_q == ST_WARMUP) ||
                     (state_q == ST_FAULT);

   ro_rng_health #(
      .REP_LIMIT (REP_LIMIT)
   ) u_health (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (hlth_clr),
      .cap_vld_i (cap_vld),
      .sample_i  (sync2_q),
      .fail_o    (fail)
   );

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      div_d   = div_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = 1'b0;
      cap_vld = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i) state_d = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (stop_i) begin
               state_d = ST_IDLE;
            end else if (warm_q == WARM_W'(WARMUP_CYC - 1)) begin
               state_d = ST_COLLECT;
            end else begin
               warm_d = warm_q + WARM_W'(1);
            end
         end
         ST_COLLECT: begin
            if (fail) begin
               state_d = ST_FAULT;
            end else if (stop_i) begin
               state_d = ST_IDLE;
            end else if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
               cap_vld = 1'b1;
               div_d   = '0;
               for (int k = 0; k < int'(N); k++) begin
                  if (idx_q == IDX_W'(k)) data_d[SAMPLE_W*k +: SAMPLE_W] = sync2_q;
               end
               if (idx_q == IDX_W'(N - 1)) begin
                  state_d = ST_HOLD;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_HOLD: begin
            // The first HOLD cycle has valid low, so valid rises one cycle
            // after the last capture and no handshake can hit that cycle.
            if (fail) begin
               state_d = ST_FAULT;
            end else if (stop_i) begin
               state_d = ST_IDLE;
            end else if (valid_q && out_ready_i) begin
               state_d = ST_COLLECT;
               div_d   = '0;
               idx_d   = '0;
            end else begin
               valid_d = 1'b1;
            end
         end
         ST_FAULT: begin
            if (fault_clr_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Leaving the active states discards any partial word.
      if (state_d == ST_IDLE || state_d == ST_FAULT) begin
         warm_d = '0;
         div_d  = '0;
         idx_d  = '0;
         data_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         warm_q  <= '0;
         div_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Decoded straight from the state register so reset drops them at once.
   assign ro_en_o     = (state_q == ST_WARMUP) || (state_q == ST_COLLECT) ||
                        (state_q == ST_HOLD);
   assign busy_o      = ro_en_o;
   assign fault_o     = (state_q == ST_FAULT);
   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;

endmodule

// File: tb/tb_ro_rng_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ro_rng_ctrl
// Directed bench for ro_rng_ctrl with default parameters. A behavioural model
// tracks phase, elapsed cycles, captured bytes and the current run of equal
// captures; a negedge process compares every output against it, and the
// directed sequence pins key cycles with hand-computed literals.
// Edge numbering: E0 is the edge that samples start; cur tracks it.
// ---------------------------------------------------------------------------
module tb_ro_rng_ctrl;

   localparam int WARMUP_CYC = 16;
   localparam int SAMPLE_DIV = 4;
   localparam int OUT_W      = 32;
   localparam int REP_LIMIT  = 8;
   localparam int N          = OUT_W / 8;

   localparam int P_IDLE = 0, P_WARM = 1, P_COLL = 2, P_HOLD = 3, P_FAULT = 4;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             start = 1'b0, stop = 1'b0, out_ready = 1'b0, fault_clr = 1'b0;
   logic [7:0]       ro_data = 8'h00;
   logic             ro_en, out_valid, busy, fault;
   logic [OUT_W-1:0] out_data;

   int n_chk = 0, n_fail = 0;
   int cur = 0;

   always #5 clk = ~clk;

   ro_rng_ctrl #(
      .WARMUP_CYC (WARMUP_CYC), .SAMPLE_DIV (SAMPLE_DIV),
      .OUT_W (OUT_W), .REP_LIMIT (REP_LIMIT)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .stop_i      (stop),
      .ro_en_o     (ro_en),
      .ro_data_i   (ro_data),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .busy_o      (busy),
      .fault_o     (fault),
      .fault_clr_i (fault_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int               ph, t, runlen;
   logic [7:0]       runval;
   logic [7:0]       sq[$];       // ro_data seen at the last two edges
   logic [7:0]       bytes_q[$];  // captures of the word being built
   logic [OUT_W-1:0] m_word;
   bit               m_valid;

   task automatic model_reset();
      ph = P_IDLE; t = 0; runlen = 0; runval = 8'h00;
      sq.delete(); sq.push_back(8'h00); sq.push_back(8'h00);
      bytes_q.delete(); m_word = '0; m_valid = 1'b0;
   endtask

   task automatic model_step();
      logic [7:0] v;
      v = sq.pop_front();          // value the synchroniser presents now
      sq.push_back(ro_data);
      case (ph)
         P_IDLE: if (start && !stop) begin ph = P_WARM; t = 0; end
         P_WARM: begin
            if (stop) ph = P_IDLE;
            else begin
               t++;
               if (t == WARMUP_CYC) begin
                  ph = P_COLL; t = 0; runlen = 0; bytes_q.delete();
               end
            end
         end
         P_COLL: begin
            if (runlen >= REP_LIMIT) begin ph = P_FAULT; m_valid = 1'b0; end
            else if (stop) ph = P_IDLE;
            else begin
               t++;
               if (t % SAMPLE_DIV == 0) begin
                  runlen = (runlen == 0 || v != runval) ? 1 : runlen + 1;
                  runval = v;
                  bytes_q.push_back(v);
                  if (bytes_q.size() == N) begin
                     m_word = '0;
                     foreach (bytes_q[k]) m_word = m_word | (OUT_W'(bytes_q[k]) << (8 * k));
                     bytes_q.delete();
                     ph = P_HOLD;
                  end
               end
            end
         end
         P_HOLD: begin
            if (runlen >= REP_LIMIT) begin ph = P_FAULT; m_valid = 1'b0; end
            else if (stop) begin ph = P_IDLE; m_valid = 1'b0; end
            else if (m_valid && out_ready) begin ph = P_COLL; t = 0; m_valid = 1'b0; end
            else m_valid = 1'b1;
         end
         P_FAULT: if (fault_clr) begin ph = P_IDLE; runlen = 0; end
         default: ph = P_IDLE;
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic act;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            act = (ph == P_WARM) || (ph == P_COLL) || (ph == P_HOLD);
            chk("ro_en", ro_en, act);
            chk("busy", busy, act);
            chk("fault", fault, ph == P_FAULT);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) chk("out_data", out_data, m_word);
            else if (ph == P_FAULT) chk("out_data_fault", out_data, 0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #2; cur++;
   endtask

   task automatic goto(input int e);
      while (cur < e) tick();
   endtask

   task automatic start_pulse();
      start = 1'b1; @(posedge clk); #2; start = 1'b0; cur = 0;
   endtask

   // Byte k is captured at e_first+4k and read from ro_data two edges earlier.
   task automatic feed(input logic [31:0] w, input int e_first);
      for (int k = 0; k < N; k++) begin
         goto(e_first - 3 + 4 * k);
         ro_data = w[8*k +: 8];
      end
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ro_en", ro_en, 0);  chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0); chk("rst_busy", busy, 0); chk("rst_fault", fault, 0);
      #1; rst_n = 1'b1;
      tick(); tick();

      // 1: first word timing and packing
      start_pulse();
      @(negedge clk); chk("t1_ro_en_E0", ro_en, 1);
      feed(32'h4433_2211, 20);
      goto(32); @(negedge clk); chk("t1_valid_E32", out_valid, 0);
      goto(33); @(negedge clk); chk("t1_valid_E33", out_valid, 1);
      chk("t1_data", out_data, 32'h4433_2211);

      // 2: backpressure for 10 cycles, then accept; next word 17 cycles later
      goto(34); ro_data = 8'h55;
      goto(43); @(negedge clk); chk("t2_valid_held", out_valid, 1);
      chk("t2_data_held", out_data, 32'h4433_2211);
      out_ready = 1'b1;
      goto(44); out_ready = 1'b0;
      feed(32'h9988_7766, 48);
      goto(60); @(negedge clk); chk("t2_valid_E60", out_valid, 0);
      goto(61); @(negedge clk); chk("t2_valid_E61", out_valid, 1);
      chk("t2_data", out_data, 32'h9988_7766);
      stop = 1'b1;
      goto(62); stop = 1'b0;
      @(negedge clk); chk("t2_stop_ro_en", ro_en, 0); chk("t2_stop_valid", out_valid, 0);

      // 3: stuck source trips the health test
      ro_data = 8'hA5; out_ready = 1'b1;
      start_pulse();
      goto(50); @(negedge clk); chk("t3_fault_E50", fault, 0);
      goto(51); @(negedge clk); chk("t3_fault_E51", fault, 1);
      chk("t3_ro_en", ro_en, 0); chk("t3_valid", out_valid, 0); chk("t3_data", out_data, 0);
      goto(53); start = 1'b1;
      goto(54); start = 1'b0;
      @(negedge clk); chk("t3_start_ignored", fault, 1); chk("t3_ro_en_off", ro_en, 0);
      fault_clr = 1'b1; start = 1'b1;
      goto(55); fault_clr = 1'b0; start = 1'b0;
      @(negedge clk); chk("t3_clr_fault", fault, 0); chk("t3_clr_ro_en", ro_en, 0);
      chk("t3_clr_busy", busy, 0);
      goto(56); @(negedge clk); chk("t3_stay_idle", ro_en, 0);

      // 4: stop after two captures, then a fresh full word
      out_ready = 1'b0; ro_data = 8'h00;
      start_pulse();
      goto(17); ro_data = 8'hB1;
      goto(21); ro_data = 8'hB2;
      goto(25); stop = 1'b1;
      goto(26); stop = 1'b0;
      @(negedge clk); chk("t4_stop_ro_en", ro_en, 0); chk("t4_stop_busy", busy, 0);
      ro_data = 8'h00;
      start_pulse();
      feed(32'hC4C3_C2C1, 20);
      goto(33); @(negedge clk); chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 32'hC4C3_C2C1);
      stop = 1'b1; tick(); stop = 1'b0;

      // 5: start+stop together, then async reset while holding a word
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      @(negedge clk); chk("t5_both_ro_en", ro_en, 0); chk("t5_both_busy", busy, 0);
      tick(); @(negedge clk); chk("t5_still_idle", ro_en, 0);
      start_pulse();
      feed(32'h0D0C_0B0A, 20);
      goto(33); @(negedge clk); chk("t5_valid", out_valid, 1);
      chk("t5_data", out_data, 32'h0D0C_0B0A);
      tick();
      rst_n = 1'b0; #1;
      chk("t5_rst_ro_en", ro_en, 0); chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_data", out_data, 0); chk("t5_rst_busy", busy, 0); chk("t5_rst_fault", fault, 0);
      #10; rst_n = 1'b1;
      tick(); tick();

      // 6: two runs of 7 split by one different byte and by word handshakes
      out_ready = 1'b1;
      start_pulse();
      feed(32'hA5A5_A5A5, 20);
      feed(32'h5AA5_A5A5, 38);
      feed(32'hA5A5_A5A5, 56);
      feed(32'h3CA5_A5A5, 74);
      goto(87); @(negedge clk); chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, 32'h3CA5_A5A5); chk("t6_no_fault", fault, 0);
      stop = 1'b1; tick(); stop = 1'b0;
      tick(); @(negedge clk); chk("t6_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
